step_dir_out: RTL and testbench
===============================

# step_dir_out

Output stage directly downstream of the per-axis pulse controller: consumes its single-cycle `pls` strobes and `dir` level and produces motor-driver STEP/DIR signals with programmable direction-setup time, step high width and minimum step low gap. It buffers up to 4 pending steps so that short controller bursts are not lost. It also keeps the axis absolute position counter, presettable by software, and flags dropped steps.

## Interface
Parameters:
- `DEPTH`, 4: pending-step buffer depth (power of two, ≥2).
- `TW`, 16: width of timing configuration fields, in `clk_ena` ticks.

Ports:
- `clk`  in  1  system clock.
- `aclr`  in  1  reset, asynchronous, active-high.
- `clk_ena`  in  1  timebase tick; all timing counters decrement only on cycles with `clk_ena`=1.
- `abort`  in  1  synchronous flush (see Operation).
- `enable`  in  1  permits starting a new step.
- `pls`  in  1  step request strobe, one `clk` cycle per step.
- `dir`  in  1  direction of the strobe sampled with `pls`; 1 = negative.
- `setup_t`  in  TW  DIR-to-STEP setup time, ticks.
- `width_t`  in  TW  STEP high time, ticks (0 treated as 1).
- `gap_t`  in  TW  STEP low time after each step, ticks.
- `inv_step`, `inv_dir`  in  1  output polarity inversion.
- `pos_wr`  in  1  position preset strobe.
- `pos_wdata`  in  32  preset value, signed.
- `ovf_clr`  in  1  clears `ovf`.
- `step_o`  out  1  STEP to driver.
- `dir_o`  out  1  DIR to driver.
- `pos`  out  32  signed absolute position.
- `busy`  out  1  state≠IDLE or buffer non-empty.
- `ovf`  out  1  sticky: a step was dropped.

## Operation
- Buffer: FIFO of direction bits, `DEPTH` entries. `pls`=1 and not full → push `dir`. `pls`=1 while full and no pop that cycle → strobe dropped, `ovf` set. Push and pop in the same cycle leave the count unchanged, and a full buffer with a simultaneous pop accepts the push.
- Registers `step_r`, `dir_r`, 32-bit `pos`, timing counter `cnt` (TW bits). `step_o = step_r ^ inv_step`, `dir_o = dir_r ^ inv_dir`.
- FSM states IDLE, SETUP, HIGH, LOW:
  - IDLE: if `enable` and buffer non-empty, pop head `d`. If `d`≠`dir_r`: `dir_r`←`d`, `cnt`←`setup_t`, go to SETUP. Else go to HIGH directly: `step_r`←1, `cnt`←max(`width_t`,1), `pos`←`pos`+1 (`d`=0) or −1 (`d`=1).
  - SETUP: on a cycle with `cnt`=0, enter HIGH with the same actions as above. Otherwise `cnt` decrements on `clk_ena`.
  - HIGH: `cnt` decrements on `clk_ena`. When `cnt`=1 and `clk_ena`=1: `step_r`←0, `cnt`←`gap_t`, go to LOW.
  - LOW: on a cycle with `cnt`=0, go to IDLE. Otherwise `cnt` decrements on `clk_ena`.
- Config inputs are sampled only when `cnt` is loaded. Changes mid-step affect the next load only.
- `enable`=0 blocks only the IDLE pop. A step already in progress completes.
- `pos` wraps modulo 2^32. If `pos_wr` coincides with a step edge, `pos_wr` wins and `pos`←`pos_wdata` exactly.
- `ovf`: set has priority over `ovf_clr` in the same cycle.
- `abort`: empties the buffer, `step_r`←0, `cnt`←0, state←IDLE. `dir_r`, `pos` and `ovf` are retained. A `pls` in the abort cycle is discarded.
- `aclr`: buffer empty, state IDLE, `step_r`=0, `dir_r`=0, `cnt`=0, `pos`=0, `ovf`=0. Outputs at reset: `step_o`=`inv_step`, `dir_o`=`inv_dir`, `pos`=0, `busy`=0, `ovf`=0.

## Timing
- Same-direction step, buffer empty: `pls` in cycle k → pushed at edge k. Pop in cycle k+1 → `step_o` active and `pos` updated from cycle k+2.
- Direction change: `dir_o` changes from cycle k+2. `step_o` activates after `setup_t` `clk_ena` ticks in SETUP plus one `clk`. With `setup_t`=0, `step_o` is active from k+3.
- HIGH lasts exactly max(`width_t`,1) `clk_ena` ticks, with the exit on the final tick.
- LOW lasts `gap_t` ticks plus one `clk`. The next IDLE pop follows one cycle after that.
- Minimum step period with `clk_ena`≡1, `width_t`=1, `gap_t`=0: 3 `clk` cycles (HIGH, LOW, IDLE).
- `busy` is combinational from the state and the buffer count.

## Test plan
- Reset, `clk_ena`≡1, `width_t`=2, `gap_t`=1, `setup_t`=3. Single `pls` with `dir`=0 → `step_o` high for 2 cycles starting at cycle k+2, `pos`=1, `dir_o` unchanged, `busy` falls afterwards.
- Same configuration, `pls` with `dir`=1 → `dir_o` rises at k+2, `step_o` rises 4 cycles later, `pos`=−1. Preset `pos_wr` with 0x7FFFFFFF, then one `dir`=0 step → `pos`=0x80000000.
- 6 back-to-back `pls` strobes, `DEPTH`=4, `width_t`=4 → the first 5 steps are emitted (4 buffered plus 1 popped) and 1 is dropped. `ovf`=1 until `ovf_clr`. Assert `ovf_clr` together with a new drop → `ovf` stays 1.
- `clk_ena` every 4th cycle, `width_t`=3 → `step_o` high 12±3 `clk` cycles. Setting `width_t`=0 → high for 1 tick.
- `abort` during HIGH with 2 steps pending → `step_o` low next cycle, `busy`=0, `pos` and `dir_o` unchanged, no further steps.
- `enable`=0 with 3 steps pending → no `step_o` activity and `busy`=1. Raise `enable` → exactly 3 steps emitted. `pos_wr` coinciding with a step edge → `pos`=`pos_wdata`.

Source files
------------

// File: rtl/step_dir_out.sv
// STEP/DIR output stage: buffers controller step strobes, sequences direction setup,
// step high and step low timing on the clk_ena timebase, and tracks absolute position.
module step_dir_out #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TW    = 16
) (
    input  logic                 clk,
    input  logic                 aclr,
    input  logic                 clk_ena,
    input  logic                 abort,
    input  logic                 enable,
    input  logic                 pls,
    input  logic                 dir,
    input  logic [TW-1:0]        setup_t,
    input  logic [TW-1:0]        width_t,
    input  logic [TW-1:0]        gap_t,
    input  logic                 inv_step,
    input  logic                 inv_dir,
    input  logic                 pos_wr,
    input  logic signed [31:0]   pos_wdata,
    input  logic                 ovf_clr,
    output logic                 step_o,
    output logic                 dir_o,
    output logic signed [31:0]   pos,
    output logic                 busy,
    output logic                 ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

    state_t             state, state_d;
    logic [DEPTH-1:0]   mem;
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               step_r, step_d;
    logic               dir_r, dir_d;
    logic [TW-1:0]      cnt, cnt_d;
    logic signed [31:0] pos_d;
    logic               pop, push, drop, step_go;
    logic               empty, full, head;
    logic [TW-1:0]      width_eff;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign head      = mem[rd_ptr];
    assign width_eff = (width_t == '0) ? TW'(1) : width_t;

    // A strobe is accepted unless the buffer stays full this cycle; abort discards it.
    assign push = pls && !abort && (!full || pop);
    assign drop = pls && !abort && full && !pop;

    // State register
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) state <= IDLE;
        else      state <= state_d;
    end

    // Next-state and datapath next values
    always_comb begin
        state_d = state;
        step_d  = step_r;
        dir_d   = dir_r;
        cnt_d   = cnt;
        pop     = 1'b0;
        step_go = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !empty) begin
                    pop = 1'b1;
                    if (head != dir_r) begin
                        dir_d   = head;
                        cnt_d   = setup_t;
                        state_d = SETUP;
                    end else begin
                        step_go = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (cnt == '0)   step_go = 1'b1;
                else if (clk_ena) cnt_d = cnt - TW'(1);
            end
            HIGH: begin
                if (clk_ena) begin
                    if (cnt <= TW'(1)) begin
                        step_d  = 1'b0;
                        cnt_d   = gap_t;
                        state_d = LOW;
                    end else begin
                        cnt_d = cnt - TW'(1);
                    end
                end
            end
            LOW: begin
                if (cnt == '0)    state_d = IDLE;
                else if (clk_ena) cnt_d = cnt - TW'(1);
            end
            default: state_d = IDLE;
        endcase
        if (step_go) begin
            step_d  = 1'b1;
            cnt_d   = width_eff;
            state_d = HIGH;
        end
        if (abort) begin
            state_d = IDLE;
            step_d  = 1'b0;
            cnt_d   = '0;
            dir_d   = dir_r;
            pop     = 1'b0;
            step_go = 1'b0;
        end
        pos_d = pos;
        if (pos_wr)       pos_d = pos_wdata;
        else if (step_go) pos_d = dir_d ? (pos - 32'sd1) : (pos + 32'sd1);
    end

    // Driver outputs and status
    always_comb begin
        step_o = step_r ^ inv_step;
        dir_o  = dir_r ^ inv_dir;
        busy   = (state != IDLE) || !empty;
    end

    // Step sequencing registers and position counter
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            step_r <= 1'b0;
            dir_r  <= 1'b0;
            cnt    <= '0;
            pos    <= '0;
        end else begin
            step_r <= step_d;
            dir_r  <= dir_d;
            cnt    <= cnt_d;
            pos    <= pos_d;
        end
    end

    // Pending-step FIFO of direction bits
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dir;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Sticky drop flag; a new drop beats a clear
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr)         ovf <= 1'b0;
        else if (drop)    ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end

endmodule

// File: tb/tb_step_dir_out.sv
// Self-checking bench for step_dir_out: directed timing checks plus randomized bursts
// compared against a step-level model (expected direction queue, widths, position).
module tb_step_dir_out;

    localparam int unsigned TW = 16;

    logic               clk = 1'b0;
    logic               aclr, clk_ena, abort, enable, pls, dir;
    logic [TW-1:0]      setup_t, width_t, gap_t;
    logic               inv_step, inv_dir, pos_wr, ovf_clr;
    logic signed [31:0] pos_wdata;
    logic               step_o, dir_o, busy, ovf;
    logic signed [31:0] pos;

    int   checks = 0;
    int   errors = 0;
    int   ena_mode = 0;
    int   ediv = 0;
    bit   obs_dir_q[$];
    int   obs_w_q[$];
    logic mon_prev = 1'b0;
    int   run_len = 0;

    step_dir_out #(.DEPTH(4), .TW(TW)) dut (
        .clk(clk), .aclr(aclr), .clk_ena(clk_ena), .abort(abort), .enable(enable),
        .pls(pls), .dir(dir), .setup_t(setup_t), .width_t(width_t), .gap_t(gap_t),
        .inv_step(inv_step), .inv_dir(inv_dir), .pos_wr(pos_wr), .pos_wdata(pos_wdata),
        .ovf_clr(ovf_clr), .step_o(step_o), .dir_o(dir_o), .pos(pos), .busy(busy), .ovf(ovf)
    );

    initial forever #5 clk = ~clk;

    // Timebase: every cycle, or every 4th cycle
    initial begin
        clk_ena = 1'b1;
        forever begin
            @(posedge clk); #1;
            ediv    = ediv + 1;
            clk_ena = (ena_mode == 0) || (ediv % 4 == 0);
        end
    end

    // Record direction at each logical step rise and the high length of each pulse
    always @(negedge clk) begin
        if (aclr) begin
            mon_prev <= 1'b0;
            run_len  <= 0;
        end else begin
            mon_prev <= step_o ^ inv_step;
            if ((step_o ^ inv_step) && !mon_prev) begin
                obs_dir_q.push_back(dir_o ^ inv_dir);
                run_len <= 1;
            end else if (step_o ^ inv_step) begin
                run_len <= run_len + 1;
            end else if (mon_prev) begin
                obs_w_q.push_back(run_len);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        chk1("idle_timeout", busy, 1'b0);
    endtask

    logic [31:0] exp_pos;
    logic        cur_dir;
    logic        d [3];
    int          base, wbase, w, len;
    logic        exp_dir_q[$];
    int          exp_w;
    logic [31:0] wdata;

    initial begin
        aclr = 1'b1; abort = 1'b0; enable = 1'b1; pls = 1'b0; dir = 1'b0;
        setup_t = TW'(3); width_t = TW'(2); gap_t = TW'(1);
        inv_step = 1'b1; inv_dir = 1'b1; pos_wr = 1'b0; pos_wdata = '0; ovf_clr = 1'b0;
        exp_pos = '0; cur_dir = 1'b0;
        #1;
        chk1("rst_step_inv", step_o, 1'b1);
        chk1("rst_dir_inv", dir_o, 1'b1);
        inv_step = 1'b0; inv_dir = 1'b0;
        #1;
        chk1("rst_step", step_o, 1'b0);
        chk1("rst_dir", dir_o, 1'b0);
        chk32("rst_pos", pos, 32'd0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ovf", ovf, 1'b0);
        repeat (2) @(posedge clk);
        #1; aclr = 1'b0;
        tick();

        // Single same-direction step
        pls = 1'b1; dir = 1'b0; tick(); pls = 1'b0;
        chk1("t1_k1_step", step_o, 1'b0);
        tick(); exp_pos = exp_pos + 32'd1;
        chk1("t1_k2_step", step_o, 1'b1);
        chk32("t1_k2_pos", pos, exp_pos);
        tick(); chk1("t1_k3_step", step_o, 1'b1);
        tick(); chk1("t1_k4_step", step_o, 1'b0);
        chk1("t1_k4_busy", busy, 1'b1);
        tick(); chk1("t1_k5_busy", busy, 1'b1);
        tick(); chk1("t1_k6_busy", busy, 1'b0);
        chk1("t1_dir", dir_o, 1'b0);

        // Direction change with setup_t=3
        pls = 1'b1; dir = 1'b1; tick(); pls = 1'b0;
        chk1("t2_k1_dir", dir_o, 1'b0);
        tick(); chk1("t2_k2_dir", dir_o, 1'b1);
        chk1("t2_k2_step", step_o, 1'b0);
        repeat (3) tick();
        chk1("t2_k5_step", step_o, 1'b0);
        tick(); exp_pos = exp_pos - 32'd1;
        chk1("t2_k6_step", step_o, 1'b1);
        chk32("t2_k6_pos", pos, exp_pos);
        tick(); chk1("t2_k7_step", step_o, 1'b1);
        tick(); chk1("t2_k8_step", step_o, 1'b0);
        wait_idle();
        pos_wr = 1'b1; pos_wdata = 32'h7FFF_FFFF; tick(); pos_wr = 1'b0;
        exp_pos = 32'h7FFF_FFFF;
        chk32("t2_preset", pos, exp_pos);
        pls = 1'b1; dir = 1'b0; tick(); pls = 1'b0;
        wait_idle();
        exp_pos = exp_pos + 32'd1;
        chk32("t2_wrap", pos, 32'h8000_0000);
        cur_dir = 1'b0;

        // Overflow: 6 back-to-back strobes, 5 emitted
        width_t = TW'(4);
        base = obs_dir_q.size();
        for (int i = 0; i < 6; i++) begin
            pls = 1'b1; dir = 1'b0;
            if (i == 5) chk1("t3_ovf_pre", ovf, 1'b0);
            tick();
        end
        pls = 1'b0;
        chk1("t3_ovf_set", ovf, 1'b1);
        wait_idle();
        chk32("t3_rises", 32'(obs_dir_q.size() - base), 32'd5);
        exp_pos = exp_pos + 32'd5;
        chk32("t3_pos", pos, exp_pos);
        chk1("t3_ovf_hold", ovf, 1'b1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk1("t3_ovf_clr", ovf, 1'b0);
        for (int i = 0; i < 6; i++) begin
            pls = 1'b1; dir = 1'b0;
            ovf_clr = (i == 5);
            tick();
        end
        pls = 1'b0; ovf_clr = 1'b0;
        chk1("t3_set_beats_clr", ovf, 1'b1);
        wait_idle();
        exp_pos = exp_pos + 32'd5;
        chk32("t3_pos2", pos, exp_pos);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

        // Slow timebase: width counted in ticks
        ena_mode = 1; width_t = TW'(3);
        wbase = obs_w_q.size();
        pls = 1'b1; dir = 1'b0; tick(); pls = 1'b0;
        wait_idle();
        chk32("t4_falls", 32'(obs_w_q.size() - wbase), 32'd1);
        w = obs_w_q[obs_w_q.size() - 1];
        chk1("t4_w3_range", (w >= 9 && w <= 12), 1'b1);
        width_t = TW'(0);
        pls = 1'b1; tick(); pls = 1'b0;
        wait_idle();
        w = obs_w_q[obs_w_q.size() - 1];
        chk1("t4_w0_range", (w >= 1 && w <= 4), 1'b1);
        exp_pos = exp_pos + 32'd2;
        chk32("t4_pos", pos, exp_pos);
        ena_mode = 0;

        // Abort during HIGH with 2 pending
        width_t = TW'(4);
        base = obs_dir_q.size();
        for (int i = 0; i < 3; i++) begin
            pls = 1'b1; dir = 1'b0; tick();
        end
        pls = 1'b0;
        exp_pos = exp_pos + 32'd1;
        chk1("t5_high", step_o, 1'b1);
        chk32("t5_pos_pre", pos, exp_pos);
        abort = 1'b1; tick(); abort = 1'b0;
        chk1("t5_step", step_o, 1'b0);
        chk1("t5_busy", busy, 1'b0);
        chk32("t5_pos", pos, exp_pos);
        chk1("t5_dir", dir_o, 1'b0);
        repeat (20) tick();
        chk32("t5_rises", 32'(obs_dir_q.size() - base), 32'd1);
        chk1("t5_busy_end", busy, 1'b0);

        // Enable gating and pos_wr on a step edge
        enable = 1'b0;
        d[0] = cur_dir; d[1] = 1'($urandom); d[2] = 1'($urandom);
        base = obs_dir_q.size();
        for (int i = 0; i < 3; i++) begin
            pls = 1'b1; dir = d[i]; tick();
        end
        pls = 1'b0;
        repeat (10) tick();
        chk1("t6_busy", busy, 1'b1);
        chk1("t6_step", step_o, 1'b0);
        chk32("t6_norise", 32'(obs_dir_q.size() - base), 32'd0);
        wdata = $urandom;
        enable = 1'b1; pos_wr = 1'b1; pos_wdata = wdata; tick(); pos_wr = 1'b0;
        chk32("t6_pos_wr", pos, wdata);
        chk1("t6_step_on", step_o, 1'b1);
        exp_pos = wdata;
        for (int i = 1; i < 3; i++) exp_pos = d[i] ? exp_pos - 32'd1 : exp_pos + 32'd1;
        wait_idle();
        chk32("t6_rises", 32'(obs_dir_q.size() - base), 32'd3);
        for (int i = 0; i < 3; i++) chk1("t6_dir", obs_dir_q[base + i], d[i]);
        chk32("t6_pos", pos, exp_pos);
        cur_dir = d[2];

        // Randomized bursts against the step-level model
        for (int r = 0; r < 8; r++) begin
            setup_t  = TW'($urandom_range(3, 0));
            width_t  = TW'($urandom_range(3, 0));
            gap_t    = TW'($urandom_range(3, 0));
            inv_step = 1'($urandom);
            inv_dir  = 1'($urandom);
            exp_w    = (width_t == '0) ? 1 : int'(width_t);
            len      = $urandom_range(4, 1);
            exp_dir_q.delete();
            base  = obs_dir_q.size();
            wbase = obs_w_q.size();
            tick();
            for (int i = 0; i < len; i++) begin
                dir = 1'($urandom);
                exp_dir_q.push_back(dir);
                exp_pos = dir ? exp_pos - 32'd1 : exp_pos + 32'd1;
                pls = 1'b1; tick(); pls = 1'b0;
                repeat ($urandom_range(2, 0)) tick();
            end
            wait_idle();
            chk32("rnd_rises", 32'(obs_dir_q.size() - base), 32'(len));
            chk32("rnd_falls", 32'(obs_w_q.size() - wbase), 32'(len));
            for (int i = 0; i < len; i++) begin
                if (base + i < obs_dir_q.size())
                    chk1("rnd_dir", obs_dir_q[base + i], exp_dir_q[i]);
                if (wbase + i < obs_w_q.size())
                    chk32("rnd_width", 32'(obs_w_q[wbase + i]), 32'(exp_w));
            end
            chk32("rnd_pos", pos, exp_pos);
            chk1("rnd_ovf", ovf, 1'b0);
            chk1("rnd_dir_o", dir_o, exp_dir_q[len - 1] ^ inv_dir);
            chk1("rnd_step_idle", step_o, inv_step);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
